// File: rtl/mux_sel_arbiter_if.sv
// Request/grant bundle between two mux sources and the select arbiter.
// master = source side (drives requests), slave = arbiter side.
interface mux_sel_arbiter_if;
  logic req1;
  logic req2;
  logic done;
  logic select;
  logic gnt1;
  logic gnt2;
  logic busy;
  logic timeout;

  modport master (
    output req1, req2, done,
    input  select, gnt1, gnt2, busy, timeout
  );

  modport slave (
    input  req1, req2, done,
    output select, gnt1, gnt2, busy, timeout
  );
endinterface

// File: rtl/mux_sel_arbiter.sv
// Two-source round-robin owner arbiter driving a registered 2:1 mux select.
// Define ARB_TIMEOUT_EN to force release after HOLD_MAX owned cycles when the other source waits.
module mux_sel_arbiter #(
  parameter int HOLD_MAX = 16,
  parameter int CW       = 5
) (
  input  logic               clk,
  input  logic               rst,
  mux_sel_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, OWN1, OWN2} state_t;

  if ((1 << CW) <= HOLD_MAX) begin : g_cw_check
    $error("mux_sel_arbiter: CW too narrow to count to HOLD_MAX");
  end

  state_t state, state_n;
  logic   last2, last2_n;   // 1 when source 2 was the most recent owner
  logic   select_n;
  logic   timeout_n;

`ifdef ARB_TIMEOUT_EN
  localparam logic [CW-1:0] HOLD_CNT = CW'(HOLD_MAX);
  logic [CW-1:0] cnt, cnt_n;
`endif

  // NOTE: every variable written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_n   = state;
    last2_n   = last2;
    select_n  = bus.select;
    timeout_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.req1 && (!bus.req2 || last2)) begin
          state_n  = OWN1;
          select_n = 1'b0;
        end else if (bus.req2) begin
          state_n  = OWN2;
          select_n = 1'b1;
        end
      end
      OWN1: begin
        if (bus.done || !bus.req1) begin
          state_n = IDLE;
          last2_n = 1'b0;
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt == HOLD_CNT && bus.req2) begin
          state_n   = IDLE;
          last2_n   = 1'b0;
          timeout_n = 1'b1;
        end
`endif
      end
      OWN2: begin
        if (bus.done || !bus.req2) begin
          state_n = IDLE;
          last2_n = 1'b1;
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt == HOLD_CNT && bus.req1) begin
          state_n   = IDLE;
          last2_n   = 1'b1;
          timeout_n = 1'b1;
        end
`endif
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef ARB_TIMEOUT_EN
  // Counter is 1 during the first owned cycle and saturates at HOLD_MAX.
  always_comb begin
    cnt_n = cnt;
    if (state == IDLE && state_n != IDLE)
      cnt_n = CW'(1);
    else if (state != IDLE && state_n != IDLE && cnt != HOLD_CNT)
      cnt_n = cnt + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt_n;
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last2       <= 1'b1;
      bus.select  <= 1'b0;
      bus.gnt1    <= 1'b0;
      bus.gnt2    <= 1'b0;
      bus.busy    <= 1'b0;
      bus.timeout <= 1'b0;
    end else begin
      state       <= state_n;
      last2       <= last2_n;
      bus.select  <= select_n;
      bus.gnt1    <= (state_n == OWN1);
      bus.gnt2    <= (state_n == OWN2);
      bus.busy    <= (state_n != IDLE);
      bus.timeout <= timeout_n;
    end
  end

endmodule
